// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core: a forward key-expansion pass reaches rk10,
// then ten inverse rounds run while the key schedule is rolled back one step per cycle.
//   IDLE | waiting for start, outputs held
//   KEXP | forward key expansion, rk0 -> rk10, folds rk10 into the state on the last step
//   DEC  | inverse rounds 9..0, key schedule stepped backwards
module aes_inv_cipher (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] din,
    output logic [127:0] dout,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, KEXP, DEC} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [127:0] dout_q, dout_d;
    logic [3:0]   rcnt_q, rcnt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // byte k of a block sits at bits [127-8k -: 8]; row r of column c is byte 4c+r
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2, x4, x8;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                a[k]  = s[127-8*(4*c+k) -: 8];
                x2    = xtime(a[k]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[k] = x8 ^ a[k];
                mb[k] = x8 ^ x2 ^ a[k];
                md[k] = x8 ^ x4 ^ a[k];
                me[k] = x8 ^ x4 ^ x2;
            end
            r[127-32*c -: 8]  = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            r[119-32*c -: 8]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            r[111-32*c -: 8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            r[103-32*c -: 8]  = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return r;
    endfunction

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  iw1, iw2, iw3;
    logic [31:0]  sub_out, rc_word, nw0;
    logic [31:0]  f1, f2, f3;
    logic [127:0] fwd_key, inv_key, isr_isb;

    assign {w0, w1, w2, w3} = rkey_q;
    assign iw3 = w3 ^ w2;
    assign iw2 = w2 ^ w1;
    assign iw1 = w1 ^ w0;

    // one SubWord shared by both directions: backwards the rotated word is the recovered w3
    assign sub_out = sub_word(rot_word((fsm_q == DEC) ? iw3 : w3));
    assign rc_word = {rcon(rcnt_q), 24'h000000};
    assign nw0     = w0 ^ sub_out ^ rc_word;

    assign f1 = w1 ^ nw0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;
    assign fwd_key = {nw0, f1, f2, f3};
    assign inv_key = {nw0, iw1, iw2, iw3};

    assign isr_isb = inv_sub_bytes(inv_shift_rows(state_q));

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        rcnt_d  = rcnt_q;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    rkey_d  = key;
                    state_d = din;
                    rcnt_d  = 4'd0;
                    busy_d  = 1'b1;
                    fsm_d   = KEXP;
                end
            end
            KEXP: begin
                rkey_d = fwd_key;
                if (rcnt_q == 4'd9) begin
                    state_d = state_q ^ fwd_key;
                    rcnt_d  = 4'd9;
                    fsm_d   = DEC;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            DEC: begin
                rkey_d = inv_key;
                if (rcnt_q != 4'd0) begin
                    state_d = inv_mix_columns(isr_isb ^ inv_key);
                    rcnt_d  = rcnt_q - 4'd1;
                end else begin
                    dout_d = isr_isb ^ inv_key;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    fsm_d  = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            rcnt_q  <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            rcnt_q  <= rcnt_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: FIPS-197 vectors, handshake corner cases,
// and random round-trips against a FIPS-197 style encryption model.
module tb_aes_inv_cipher;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [127:0] din;
    logic [127:0] dout;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_inv_cipher dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .key   (key),
        .din   (din),
        .dout  (dout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]   sbox_t [256];
    logic [127:0] rks [11];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // walk the generator 3 and its inverse together to fill the table
    function automatic void build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01; q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endfunction

    function automatic logic [31:0] m_subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic void expand_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = m_subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] m_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox_t[s[127-8*k -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] m_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] m_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s;
        expand_key(k);
        s = pt ^ rks[0];
        for (int r = 1; r <= 10; r++) begin
            s = m_shift_rows(m_sub_bytes(s));
            if (r != 10) s = m_mix_columns(s);
            s = s ^ rks[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus helpers ----------------
    // leaves the bench at the falling edge right after the accepting edge
    task automatic start_op(input logic [127:0] k, input logic [127:0] d);
        @(negedge clk);
        key   = k;
        din   = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key   = rand128();
        din   = rand128();
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; key = '0; din = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (dout !== 128'h0) begin n_err++; $display("FAIL reset_dout: got %h want 0", dout); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
    endtask

    task automatic test_fips_c1();
        int cyc;
        start_op(C1_KEY, C1_CT);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL c1_busy_rise: got %b want 1", busy); end
        wait_done(cyc);
        n_cmp++; if (cyc !== 20) begin n_err++; $display("FAIL c1_latency: got %0d want 20", cyc); end
        n_cmp++; if (dout !== C1_PT) begin n_err++; $display("FAIL c1_dout: got %h want %h", dout, C1_PT); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL c1_busy_fall: got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL c1_done_pulse: got %b want 0", done); end
        n_cmp++; if (dout !== C1_PT) begin n_err++; $display("FAIL c1_dout_hold: got %h want %h", dout, C1_PT); end
    endtask

    task automatic test_fips_b();
        int cyc;
        start_op(B_KEY, B_CT);
        repeat (10) @(negedge clk);
        n_cmp++; if (dut.rkey_q !== B_RK10) begin n_err++; $display("FAIL b_rk10: got %h want %h", dut.rkey_q, B_RK10); end
        wait_done(cyc);
        n_cmp++; if (cyc + 10 !== 20) begin n_err++; $display("FAIL b_latency: got %0d want 20", cyc + 10); end
        n_cmp++; if (dout !== B_PT) begin n_err++; $display("FAIL b_dout: got %h want %h", dout, B_PT); end
    endtask

    task automatic test_ignored_starts();
        int cyc;
        int extra;
        start_op(C1_KEY, C1_CT);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
            start = (i == 3 || i == 9);
            if (start) begin
                key = rand128();
                din = rand128();
            end
        end
        start = 1'b0;
        n_cmp++; if (cyc !== 20) begin n_err++; $display("FAIL ign_latency: got %0d want 20", cyc); end
        n_cmp++; if (dout !== C1_PT) begin n_err++; $display("FAIL ign_dout: got %h want %h", dout, C1_PT); end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL ign_extra_done: got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op(C1_KEY, C1_CT);
        wait_done(cyc);
        n_cmp++; if (cyc !== 20) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 20", cyc); end
        n_cmp++; if (dout !== C1_PT) begin n_err++; $display("FAIL b2b_first_dout: got %h want %h", dout, C1_PT); end
        key = B_KEY; din = B_CT; start = 1'b1;
        @(negedge clk);
        start = 1'b0; key = rand128(); din = rand128();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
            n_cmp++;
            if (dout !== C1_PT) begin n_err++; $display("FAIL b2b_hold cycle %0d: got %h want %h", i, dout, C1_PT); end
        end
        n_cmp++; if (cyc !== 20) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 20", cyc); end
        n_cmp++; if (dout !== B_PT) begin n_err++; $display("FAIL b2b_second_dout: got %h want %h", dout, B_PT); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        start_op(C1_KEY, C1_CT);
        repeat (12) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (dout !== 128'h0) begin n_err++; $display("FAIL rmid_dout: got %h want 0", dout); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rmid_no_done: got %0d pulses want 0", seen); end
        start_op(C1_KEY, C1_CT);
        wait_done(cyc);
        n_cmp++; if (cyc !== 20) begin n_err++; $display("FAIL rmid_rerun_latency: got %0d want 20", cyc); end
        n_cmp++; if (dout !== C1_PT) begin n_err++; $display("FAIL rmid_rerun_dout: got %h want %h", dout, C1_PT); end
    endtask

    task automatic test_round_trip();
        logic [127:0] k, pt, ct;
        int cyc;
        for (int n = 0; n < 100; n++) begin
            k  = rand128();
            pt = rand128();
            ct = model_encrypt(pt, k);
            start_op(k, ct);
            wait_done(cyc);
            n_cmp++;
            if (cyc !== 20 || dout !== pt) begin
                n_err++;
                $display("FAIL round_trip #%0d: got %h after %0d cycles want %h after 20", n, dout, cyc, pt);
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_ignored_starts();
        test_back_to_back();
        test_reset_mid();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
